mem_port_ctrl: RTL
==================

# mem_port_ctrl

Memory-side responder between the multi-cycle CPU control path and the synchronous word-wide `Memoria` RAM. It accepts one load or store request at a time through a req/ack handshake. It performs word, halfword and byte accesses on a byte-addressed, little-endian space, using read-modify-write for sub-word stores. It returns zero-extended load data and flags misaligned accesses instead of touching memory.

## Interface
Parameters:
- `MEM_LAT`, default 1: RAM read latency in cycles. Allowed range 1–7. Data is valid on `mem_rdata` MEM_LAT cycles after `mem_addr` is driven.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe. Sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word. 11 is treated as word.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 32: load result, zero-extended. Valid with `ack` and held until the next load `ack`.
- `addr_err` out 1: pulses with `ack` for a misaligned request.
- `busy` out 1: high whenever state ≠ IDLE.
- `mem_addr` out 32: word address to RAM, `{addr[31:2],2'b00}`.
- `mem_wr` out 1: RAM write enable.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data.

## Operation
- **States:** IDLE, CHECK, RD_WAIT, MERGE, WR, DONE.
- **IDLE:**
  - On `req`=1, latch `we`, `size`, `addr`, `wdata`, then go to CHECK.
  - `req` in any other state is ignored. It is not queued.
- **CHECK** (alignment test):
  - Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Misaligned request → DONE with `addr_err` set. No RAM access; `mem_wr` stays 0.
  - Word store → WR.
  - Any load or sub-word store → RD_WAIT. Load the latency counter with MEM_LAT.
- **RD_WAIT:**
  - Drive `mem_addr` and decrement the counter.
  - When the counter reaches 0, capture `mem_rdata` into the internal word register.
  - Load → DONE. Sub-word store → MERGE.
- **Load extraction** (applied on capture):
  - Byte: lane `addr[1:0]`, i.e. bits [8k+7:8k] → `rdata[7:0]`, upper 24 bits 0.
  - Halfword: `addr[1]`=0 takes bits [15:0], `addr[1]`=1 takes bits [31:16] → `rdata[15:0]`, upper 16 bits 0.
  - Word: passes through unchanged.
- **MERGE:** replace only the addressed byte or halfword of the captured word with `wdata[7:0]` or `wdata[15:0]`; all other bits are preserved. Then → WR.
- **WR:**
  - `mem_wr`=1 for exactly one cycle.
  - `mem_wdata` is the merged word, or `wdata` for a word store.
  - Then → DONE.
- **DONE:** `ack`=1 for one cycle, then → IDLE.
- **Output defaults:** `mem_wr` is 0 in every state except WR. `mem_addr` is held at the latched word address from CHECK through DONE.

## Timing
- **Reset values:**
  - `ack`, `addr_err`, `busy`, `mem_wr` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
  - State = IDLE.
- **Latency** (request accepted at edge T, so `busy` rises at T+1):
  - Misaligned: `ack`+`addr_err` at T+2.
  - Word store: `mem_wr` at T+2, `ack` at T+3.
  - Load: `ack` at T+2+MEM_LAT+1, with `rdata` valid in that cycle.
  - Sub-word store: `mem_wr` at T+2+MEM_LAT+2, `ack` one cycle later.
- **Back-to-back:** the earliest next acceptance is the cycle after `ack` (IDLE). `busy` is low in that cycle.
- **Output hold rules:**
  - `rdata` changes only on a successful load completion.
  - A store or an error leaves `rdata` unchanged.
- **Reset mid-operation:**
  - The next edge forces IDLE and clears all outputs. No `ack` is issued for the aborted request.
  - If reset is high in the WR cycle, that write still occurs (`mem_wr` is already registered). No further write follows.
- **Simultaneous events:** `req` in the DONE cycle is ignored. The requester must hold or re-raise `req` once `busy`=0.

## Test plan
All scenarios use MEM_LAT=1.
1. **Word load:** RAM[0x10]=0xDEADBEEF; load word at 0x10 → `ack` 4 cycles after acceptance, `rdata`=0xDEADBEEF, `mem_wr` never high.
2. **Byte load, all lanes:** byte loads at 0x11 and 0x13 → `rdata`=0x000000BE, then 0x000000DE. Halfword load at 0x12 → 0x0000DEAD.
3. **Byte store RMW:** store byte 0x55 at 0x12 → exactly one `mem_wr` pulse; RAM[0x10]=0xDE55BEEF. Halfword store 0x1234 at 0x10 → 0xDE551234.
4. **Word store:** store word 0xCAFEF00D at 0x20 → `mem_wr` at T+2, `ack` at T+3, RAM[0x20]=0xCAFEF00D, `rdata` unchanged.
5. **Misaligned:** word load at 0x22, then halfword store at 0x21 → each gives `ack`+`addr_err` at T+2, no `mem_wr`, RAM unchanged, `rdata` unchanged.
6. **Reset and busy:** assert reset during RD_WAIT of a byte store → no `mem_wr`, no `ack`, `busy`=0 on the next cycle. `req` pulsed while busy → ignored, exactly one `ack` per accepted request.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Single-request memory responder: word/half/byte loads and stores on a little-endian byte space, RMW for sub-word stores.
// States: IDLE wait req | CHECK alignment test | RD_WAIT RAM read | MERGE patch sub-word | WR write word | DONE ack pulse
module mem_port_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_addr_err,
    output logic        o_busy,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD_WAIT, S_MERGE, S_WR, S_DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      r_state, w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [2:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] r_rdata;

    logic        w_misaligned;
    logic        w_word_store;
    logic        w_cnt_zero;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    assign w_misaligned = ((r_size == 2'b01) && r_addr[0]) ||
                          (r_size[1] && (r_addr[1:0] != 2'b00));
    assign w_word_store = r_we && r_size[1];
    assign w_cnt_zero   = (r_cnt == 3'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_req) w_next = S_CHECK;
            S_CHECK: begin
                if (w_misaligned)      w_next = S_DONE;
                else if (w_word_store) w_next = S_WR;
                else                   w_next = S_RD_WAIT;
            end
            S_RD_WAIT: if (w_cnt_zero) w_next = r_we ? S_MERGE : S_DONE;
            S_MERGE:   w_next = S_WR;
            S_WR:      w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Load extraction: size 11 behaves as a word.
    always_comb begin
        w_load_val = i_mem_rdata;
        case (r_size)
            2'b00:   w_load_val = {24'b0, i_mem_rdata[{r_addr[1:0], 3'b000} +: 8]};
            2'b01:   w_load_val = {16'b0, i_mem_rdata[{r_addr[1], 4'b0000} +: 16]};
            default: w_load_val = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        if (r_size == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else if (r_size == 2'b01)
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_err   <= 1'b0;
            r_cnt   <= 3'd0;
            r_word  <= 32'b0;
            r_rdata <= 32'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_size  <= i_size;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                    end
                end
                S_CHECK: begin
                    r_err <= w_misaligned;
                    r_cnt <= LAT;
                    if (w_word_store) r_word <= r_wdata;
                end
                S_RD_WAIT: begin
                    if (w_cnt_zero) begin
                        r_word <= i_mem_rdata;
                        if (!r_we) r_rdata <= w_load_val;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_MERGE: r_word <= w_merged;
                default: ;
            endcase
        end
    end

    assign o_ack       = (r_state == S_DONE);
    assign o_addr_err  = (r_state == S_DONE) && r_err;
    assign o_busy      = (r_state != S_IDLE);
    assign o_mem_wr    = (r_state == S_WR);
    assign o_mem_addr  = {r_addr[31:2], 2'b00};
    assign o_mem_wdata = r_word;
    assign o_rdata     = r_rdata;

endmodule
